// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - button/tick inputs and counter-enable outputs of time_set_ctrl
interface time_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] sec;
  logic [7:0] min;
  logic       sec_en;
  logic       min_en;
  logic       hour_en;
  logic       dir;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output tick_1hz, btn_mode, btn_up, btn_down, sec, min,
    input  sec_en, min_en, hour_en, dir, mode, blink
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_up, btn_down, sec, min,
    output sec_en, min_en, hour_en, dir, mode, blink
  );
endinterface

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - run/set mode and count-enable controller for the clock counter chain
// Optional: TIME_SET_AUTO_REPEAT_EN adds held-button auto-repeat of up/down steps in SET modes.
module time_set_ctrl #(
  parameter int unsigned REPEAT_DELAY = 8,
  parameter int unsigned REPEAT_RATE  = 4
) (
  input  logic           CP,
  input  logic           nCLR,
  time_set_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10,
    SET_SEC  = 2'b11
  } mode_e;

  mode_e mode_q, mode_d;
  logic  sec_en_q, sec_en_d;
  logic  min_en_q, min_en_d;
  logic  hour_en_q, hour_en_d;
  logic  dir_q, dir_d;
  logic  blink_q, blink_d;

  // Per button: [0] first sync flop, [1] second sync flop, [2] previous synced level
  logic [2:0] mode_sync_q, up_sync_q, down_sync_q;
  logic       mode_press, up_press, down_press;
  logic       edge_up, edge_down;
  logic       step_up, step_down;

  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_repeat_cfg_unusable
  end

  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) begin
      mode_sync_q <= 3'b000;
      up_sync_q   <= 3'b000;
      down_sync_q <= 3'b000;
    end else begin
      mode_sync_q <= {mode_sync_q[1:0], bus.btn_mode};
      up_sync_q   <= {up_sync_q[1:0], bus.btn_up};
      down_sync_q <= {down_sync_q[1:0], bus.btn_down};
    end
  end

  assign mode_press = mode_sync_q[1] & ~mode_sync_q[2];
  assign up_press   = up_sync_q[1] & ~up_sync_q[2];
  assign down_press = down_sync_q[1] & ~down_sync_q[2];

  // A mode press or a simultaneous up+down press drops the step
  assign edge_up   = up_press & ~down_press & ~mode_press & (mode_q != RUN);
  assign edge_down = down_press & ~up_press & ~mode_press & (mode_q != RUN);

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int unsigned CW = 16;

  logic          rep_act_q, rep_act_d;
  logic          rep_up_q, rep_up_d;
  logic          rep_phase_q, rep_phase_d;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic [CW-1:0] rep_limit;
  logic          rep_held, rep_fire, edge_any;

  assign edge_any  = edge_up | edge_down;
  assign rep_held  = rep_up_q ? up_sync_q[1] : down_sync_q[1];
  assign rep_limit = rep_phase_q ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
  assign rep_fire  = rep_act_q & rep_held & ~mode_press & (mode_q != RUN) & (rep_cnt_q == rep_limit);

  // rep_cnt_q counts cycles since the last issued step, starting at 1 after it
  always_comb begin
    rep_act_d   = rep_act_q;
    rep_up_d    = rep_up_q;
    rep_phase_d = rep_phase_q;
    rep_cnt_d   = rep_cnt_q;
    if (edge_any) begin
      rep_act_d   = 1'b1;
      rep_up_d    = edge_up;
      rep_phase_d = 1'b0;
      rep_cnt_d   = CW'(1);
    end else if (rep_act_q) begin
      if (!rep_held || mode_press || mode_q == RUN) begin
        rep_act_d   = 1'b0;
        rep_phase_d = 1'b0;
        rep_cnt_d   = '0;
      end else if (rep_fire) begin
        rep_phase_d = 1'b1;
        rep_cnt_d   = CW'(1);
      end else begin
        rep_cnt_d = rep_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) begin
      rep_act_q   <= 1'b0;
      rep_up_q    <= 1'b0;
      rep_phase_q <= 1'b0;
      rep_cnt_q   <= '0;
    end else begin
      rep_act_q   <= rep_act_d;
      rep_up_q    <= rep_up_d;
      rep_phase_q <= rep_phase_d;
      rep_cnt_q   <= rep_cnt_d;
    end
  end

  assign step_up   = edge_up | (rep_fire & rep_up_q & ~edge_any);
  assign step_down = edge_down | (rep_fire & ~rep_up_q & ~edge_any);
`else
  assign step_up   = edge_up;
  assign step_down = edge_down;
`endif

  always_ff @(posedge CP or negedge nCLR) begin
    if (!nCLR) begin
      mode_q    <= RUN;
      sec_en_q  <= 1'b0;
      min_en_q  <= 1'b0;
      hour_en_q <= 1'b0;
      dir_q     <= 1'b1;
      blink_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      sec_en_q  <= sec_en_d;
      min_en_q  <= min_en_d;
      hour_en_q <= hour_en_d;
      dir_q     <= dir_d;
      blink_q   <= blink_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_press) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end
  end

  always_comb begin
    sec_en_d  = 1'b0;
    min_en_d  = 1'b0;
    hour_en_d = 1'b0;
    dir_d     = dir_q;
    blink_d   = blink_q;
    if (mode_q == RUN) begin
      dir_d   = 1'b1;
      blink_d = 1'b0;
      if (bus.tick_1hz) begin
        sec_en_d  = 1'b1;
        min_en_d  = (bus.sec == 8'h59);
        hour_en_d = (bus.sec == 8'h59) && (bus.min == 8'h59);
      end
    end else begin
      if (bus.tick_1hz) begin
        blink_d = ~blink_q;
      end
      if (step_up || step_down) begin
        dir_d = step_up;
        case (mode_q)
          SET_HOUR: hour_en_d = 1'b1;
          SET_MIN:  min_en_d  = 1'b1;
          SET_SEC:  sec_en_d  = 1'b1;
          default:  ;
        endcase
      end
    end
    // Mode entry overrides any tick-driven blink toggle in the same cycle
    if (mode_press) begin
      if (mode_d == RUN) begin
        dir_d   = 1'b1;
        blink_d = 1'b0;
      end else begin
        blink_d = 1'b1;
      end
    end
  end

  assign bus.sec_en  = sec_en_q;
  assign bus.min_en  = min_en_q;
  assign bus.hour_en = hour_en_q;
  assign bus.dir     = dir_q;
  assign bus.mode    = mode_q;
  assign bus.blink   = blink_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - randomized self-checking bench for time_set_ctrl
module tb_time_set_ctrl;
  localparam int unsigned RD = 8;
  localparam int unsigned RR = 4;

  logic clk  = 1'b0;
  logic nclr = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_mode;
  bit   m_dir;
  bit   m_blink;
  logic [31:0] hits;
  logic [31:0] exp_hits;
  int   r;

  time_set_ctrl_if bus();

  time_set_ctrl #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .CP   (clk),
    .nCLR (nclr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Enables packed as {sec_en, min_en, hour_en}
  task automatic chk_en(input string tag, input logic [2:0] e);
    chk(tag, {29'd0, bus.sec_en, bus.min_en, bus.hour_en}, {29'd0, e});
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_mode"}, {30'd0, bus.mode}, m_mode);
    chk({tag, "_dir"}, {31'd0, bus.dir}, {31'd0, m_dir});
    chk({tag, "_blink"}, {31'd0, bus.blink}, {31'd0, m_blink});
  endtask

  function automatic int bcd2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] rand_bcd();
    int v;
    v = ($urandom_range(0, 3) == 0) ? 59 : int'($urandom_range(0, 59));
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic tick_chk(input logic [7:0] s, input logic [7:0] m);
    logic [2:0] e;
    bit s59, m59;
    s59 = (bcd2i(s) == 59);
    m59 = (bcd2i(m) == 59);
    e   = 3'b000;
    if (m_mode == 0) e = {1'b1, s59, s59 && m59};
    else m_blink = ~m_blink;
    bus.sec = s;
    bus.min = m;
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
    chk_en("tick_en", e);
    chk_state("tick");
    cyc();
    chk_en("tick_single", 3'b000);
  endtask

  task automatic press(input bit up, input bit dn, input bit md);
    logic [2:0] e;
    int old_mode;
    e = 3'b000;
    old_mode = m_mode;
    bus.btn_up = up;
    bus.btn_down = dn;
    bus.btn_mode = md;
    cyc();
    cyc();
    chk("press_latency_mode", {30'd0, bus.mode}, old_mode);
    chk_en("press_latency_en", 3'b000);
    if (md) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 0) begin
        m_dir = 1'b1;
        m_blink = 1'b0;
      end else begin
        m_blink = 1'b1;
      end
    end else if (up != dn && m_mode != 0) begin
      m_dir = up;
      e = (m_mode == 1) ? 3'b001 : (m_mode == 2) ? 3'b010 : 3'b100;
    end
    cyc();
    chk_en("press_en", e);
    chk_state("press");
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_mode = 1'b0;
    cyc();
    chk_en("press_single", 3'b000);
    repeat (3) cyc();
  endtask

  initial begin
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.sec      = 8'h12;
    bus.min      = 8'h34;
    m_mode  = 0;
    m_dir   = 1'b1;
    m_blink = 1'b0;

    repeat (3) cyc();
    chk_state("reset");
    chk_en("reset_en", 3'b000);
    nclr = 1'b1;
    cyc();
    chk_state("post_reset");

    tick_chk(8'h12, 8'h34);
    tick_chk(8'h59, 8'h59);
    tick_chk(8'h59, 8'h10);
    for (int i = 0; i < 20; i++) tick_chk(rand_bcd(), rand_bcd());

    // Mode press and tick land together in RUN: tick enables still issued
    bus.btn_mode = 1'b1;
    cyc();
    cyc();
    bus.sec = 8'h59;
    bus.min = 8'h00;
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
    m_mode  = 1;
    m_blink = 1'b1;
    chk_en("run_tick_mode_en", 3'b110);
    chk_state("run_tick_mode");
    bus.btn_mode = 1'b0;
    repeat (4) cyc();

    press(1, 0, 0);
    press(0, 1, 0);
    tick_chk(8'h00, 8'h00);
    tick_chk(8'h59, 8'h59);
    press(0, 0, 1);
    press(0, 0, 1);
    press(0, 0, 1);
    press(1, 0, 0);
    press(1, 0, 1);
    press(1, 1, 0);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    press(0, 0, 1);
        2, 3, 4: press(1, 0, 0);
        5, 6, 7: press(0, 1, 0);
        8:       tick_chk(rand_bcd(), rand_bcd());
        default: press(1, 1, 0);
      endcase
    end

    // Tick coinciding with SET_SEC -> RUN is dropped
    while (m_mode != 3) press(0, 0, 1);
    bus.btn_mode = 1'b1;
    cyc();
    cyc();
    bus.sec = 8'h59;
    bus.min = 8'h59;
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
    m_mode  = 0;
    m_dir   = 1'b1;
    m_blink = 1'b0;
    chk_en("sec_to_run_tick_en", 3'b000);
    chk_state("sec_to_run_tick");
    bus.btn_mode = 1'b0;
    repeat (4) cyc();

    // Hold up for 20 sampled cycles in SET_MIN
    press(0, 0, 1);
    press(0, 0, 1);
    hits = 32'd0;
    bus.btn_up = 1'b1;
    for (int i = 0; i < 26; i++) begin
      cyc();
      if (bus.min_en === 1'b1) hits[i] = 1'b1;
      if (bus.sec_en === 1'b1 || bus.hour_en === 1'b1) hits[31] = 1'b1;
      if (i == 19) bus.btn_up = 1'b0;
    end
`ifdef TIME_SET_AUTO_REPEAT_EN
    exp_hits = (32'd1 << 2) | (32'd1 << (2 + RD)) | (32'd1 << (2 + RD + RR)) | (32'd1 << (2 + RD + 2 * RR));
`else
    exp_hits = 32'd1 << 2;
`endif
    chk("hold_up_steps", hits, exp_hits);
    m_dir = 1'b1;
    chk_state("hold_up");
    repeat (4) cyc();

    // Reset while a SET_SEC down-step pulse is on the output
    press(0, 0, 1);
    bus.btn_down = 1'b1;
    cyc();
    cyc();
    cyc();
    chk_en("rst_pre_en", 3'b100);
    chk("rst_pre_dir", {31'd0, bus.dir}, 32'd0);
    #2;
    nclr = 1'b0;
    #1;
    m_mode  = 0;
    m_dir   = 1'b1;
    m_blink = 1'b0;
    chk_en("rst_kill_en", 3'b000);
    chk_state("rst_kill");
    bus.btn_down = 1'b0;
    @(negedge clk);
    nclr = 1'b1;
    repeat (4) cyc();
    tick_chk(8'h05, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Mode and count-enable controller for the digital clock's seconds/minutes/hours counter chain. Each counter already has a count enable, a direction input and a BCD value output; this block drives those inputs. In run mode it turns the 1 Hz tick into enable pulses, including the sec→min→hour carries. In set modes it freezes time and turns debounced push-button presses into single up/down steps on the selected field.

## Interface
Parameters:
- REPEAT_DELAY, 8: CP cycles a step button must stay held after its first step before auto-repeat starts.
- REPEAT_RATE, 4: CP cycles between auto-repeat steps.

Ports:
- CP  in  1  system clock, rising edge
- nCLR  in  1  asynchronous active-low reset
- tick_1hz  in  1  synchronous one-CP-cycle pulse, once per second; consecutive pulses are ≥2 cycles apart
- btn_mode  in  1  debounced level, asynchronous to CP
- btn_up  in  1  debounced level, asynchronous to CP
- btn_down  in  1  debounced level, asynchronous to CP
- sec  in  8  current seconds, BCD 00–59
- min  in  8  current minutes, BCD 00–59
- sec_en  out  1  one-cycle count enable to the seconds counter
- min_en  out  1  one-cycle count enable to the minutes counter
- hour_en  out  1  one-cycle count enable to the hours counter
- dir  out  1  count direction: 1 = up, 0 = down
- mode  out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
- blink  out  1  display blank strobe for the selected field

## Operation
- All outputs are registered. Reset values: sec_en=min_en=hour_en=0, dir=1, mode=00, blink=0. All synchronizers, edge detectors and repeat counters clear to 0.
- Each button passes through a 2-flop synchronizer and then a rising-edge detector, producing an internal press pulse.
- Mode sequence on each mode press: RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- RUN:
  - dir=1.
  - On each tick_1hz: pulse sec_en.
  - Also pulse min_en if sec==8'h59 at the tick.
  - Also pulse hour_en if sec==8'h59 and min==8'h59 at the tick.
  - Button up/down presses are ignored.
- SET_x:
  - tick_1hz never produces an enable, so time is frozen.
  - An up press pulses only the selected field's enable with dir=1.
  - A down press does the same with dir=0.
  - There is no carry into other fields; the counters wrap on their own (59→00, 00→59).
  - dir holds its last value between steps. It returns to 1 when RUN is entered.
- blink:
  - Is 0 in RUN.
  - Is set to 1 on entering any SET mode.
  - Toggles on each tick_1hz while in a SET mode.
- Simultaneous events:
  - A mode press in the same cycle as an up/down press: the mode press wins and the step is dropped.
  - Up and down pressed in the same cycle: both are ignored.
  - A tick in the same cycle as the SET_SEC→RUN transition is ignored.
  - A mode press in RUN in the same cycle as a tick: the tick's enables are still issued and the mode advances.
- Reset mid-operation: any in-flight enable pulse is killed immediately, and the block returns to RUN.

## Timing
- Tick latency: tick sampled high at edge k → enables high for exactly the cycle following edge k.
- Button latency: button first sampled high at edge k → enable/mode/dir update takes effect at edge k+2 (sync1 at k, sync2 at k+1, registered output at k+2).
- dir is valid in the same cycle as its enable pulse.
- Every enable is high for exactly one CP cycle per event.

## Configuration
- Macro: TIME_SET_AUTO_REPEAT_EN.
- Defined:
  - The repeat function applies only to up/down in a SET mode.
  - While the synchronized button stays high, a further step is issued REPEAT_DELAY cycles after the edge step, then one every REPEAT_RATE cycles.
  - Releasing the button, a mode change, or reset stops repeating and clears the counters.
- Undefined:
  - One step per press, no matter how long the button is held.
  - The repeat counters are not built; the parameters are accepted but unused.

## Test plan
- Reset with nCLR=0, then release: mode=00, dir=1, blink=0, all enables 0. With sec=8'h12, min=8'h34, pulse tick → sec_en only, for 1 cycle, one cycle after the tick.
- RUN with sec=8'h59, min=8'h59, tick → sec_en, min_en and hour_en together for one cycle. With sec=8'h59, min=8'h10 → sec_en and min_en only.
- Press mode once, then up: mode=01, blink=1, hour_en pulses with dir=1 at edge k+2. Press down → hour_en with dir=0. Ticks produce no enables and toggle blink.
- Cycle mode four times → 01, 10, 11, 00. After returning to RUN, dir=1 and blink=0. btn_mode and btn_up rising in the same cycle → mode advances and no enable is issued.
- With TIME_SET_AUTO_REPEAT_EN defined, hold up for 20 cycles in SET_MIN (REPEAT_DELAY=8, REPEAT_RATE=4) → min_en at edge-step+0, +8, +12, +16. With the macro undefined → a single min_en.
- Assert nCLR during SET_SEC while a step pulse is in flight → enable drops immediately, mode=00, dir=1.
